// File: rtl/uart_xcvr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_xcvr                                                    |
// | Description : Parametrised full-duplex UART transceiver with valid/ready   |
// |               host handshakes, one-word RX holding register, and framing,  |
// |               parity and overrun error pulses.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_xcvr #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic                 tx_out,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int c_TMR_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_HALF = c_TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic c_HAS_PAR   = (PARITY != 0);
    localparam logic c_ODD       = (PARITY == 1);
    localparam logic c_STOP_LAST = (STOP_BITS == 2);

    // State encoding shared by both directions (BREAK is RX only)
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_BREAK  = 3'd5;

    // ------------------------------------------------------------------ TX
    logic [2:0]           r_tx_state, w_tx_state_nxt;
    logic [c_TMR_W-1:0]   r_tx_tmr;
    logic [c_IDX_W-1:0]   r_tx_idx;
    logic                 r_tx_stop_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_out;
    logic                 w_tx_tick;

    assign w_tx_tick = (r_tx_tmr == c_TMR_LAST);
    assign tx_ready  = (r_tx_state == c_ST_IDLE);
    assign tx_out    = r_tx_out;

    // TX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= c_ST_IDLE;
        else     r_tx_state <= w_tx_state_nxt;
    end

    // TX next-state: each bit period ends on the timer's last count
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            c_ST_IDLE:   if (tx_valid) w_tx_state_nxt = c_ST_START;
            c_ST_START:  if (w_tx_tick) w_tx_state_nxt = c_ST_DATA;
            c_ST_DATA:   if (w_tx_tick && r_tx_idx == c_IDX_LAST)
                             w_tx_state_nxt = c_HAS_PAR ? c_ST_PARITY : c_ST_STOP;
            c_ST_PARITY: if (w_tx_tick) w_tx_state_nxt = c_ST_STOP;
            c_ST_STOP:   if (w_tx_tick && r_tx_stop_idx == c_STOP_LAST)
                             w_tx_state_nxt = c_ST_IDLE;
            default:     w_tx_state_nxt = c_ST_IDLE;
        endcase
    end

    // TX datapath: tx_out is registered so the line changes on the state transition edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_tmr      <= '0;
            r_tx_idx      <= '0;
            r_tx_stop_idx <= 1'b0;
            r_tx_shift    <= '0;
            r_tx_par      <= 1'b0;
            r_tx_out      <= 1'b1;
        end else if (r_tx_state == c_ST_IDLE) begin
            r_tx_tmr      <= '0;
            r_tx_idx      <= '0;
            r_tx_stop_idx <= 1'b0;
            if (tx_valid) begin
                r_tx_shift <= tx_data;
                r_tx_par   <= c_ODD ? ~^tx_data : ^tx_data;
                r_tx_out   <= 1'b0;
            end
        end else begin
            r_tx_tmr <= w_tx_tick ? '0 : r_tx_tmr + 1'b1;
            if (w_tx_tick) begin
                case (r_tx_state)
                    c_ST_START: r_tx_out <= r_tx_shift[0];
                    c_ST_DATA: begin
                        if (r_tx_idx == c_IDX_LAST) begin
                            r_tx_out <= c_HAS_PAR ? r_tx_par : 1'b1;
                        end else begin
                            r_tx_out   <= r_tx_shift[1];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_idx   <= r_tx_idx + 1'b1;
                        end
                    end
                    c_ST_PARITY: r_tx_out <= 1'b1;
                    c_ST_STOP: begin
                        r_tx_out      <= 1'b1;
                        r_tx_stop_idx <= 1'b1;
                    end
                    default: r_tx_out <= 1'b1;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------ RX
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx;
    logic [2:0]             r_rx_state, w_rx_state_nxt;
    logic [c_TMR_W-1:0]     r_rx_tmr;
    logic [c_IDX_W-1:0]     r_rx_idx;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   r_rx_par;
    logic                   r_rx_armed;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_frame_err, r_rx_parity_err, r_rx_overrun;
    logic                   w_rx_tick, w_rx_wrap;

    assign w_rx          = r_sync[SYNC_STAGES-1];
    assign w_rx_tick     = (r_rx_tmr == c_TMR_LAST);
    assign w_rx_wrap     = (r_rx_state == c_ST_START) ? (r_rx_tmr == c_TMR_HALF) : w_rx_tick;
    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_frame_err  = r_rx_frame_err;
    assign rx_parity_err = r_rx_parity_err;
    assign rx_overrun    = r_rx_overrun;

    // Input synchroniser; resets to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
    end

    // RX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= c_ST_IDLE;
        else     r_rx_state <= w_rx_state_nxt;
    end

    // RX next-state: half-bit start qualification, then mid-bit sampling
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            c_ST_IDLE:   if (r_rx_armed && !w_rx) w_rx_state_nxt = c_ST_START;
            c_ST_START:  if (w_rx_wrap) w_rx_state_nxt = w_rx ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:   if (w_rx_tick && r_rx_idx == c_IDX_LAST)
                             w_rx_state_nxt = c_HAS_PAR ? c_ST_PARITY : c_ST_STOP;
            c_ST_PARITY: if (w_rx_tick) w_rx_state_nxt = c_ST_STOP;
            c_ST_STOP:   if (w_rx_tick) w_rx_state_nxt = w_rx ? c_ST_IDLE : c_ST_BREAK;
            c_ST_BREAK:  if (w_rx) w_rx_state_nxt = c_ST_IDLE;
            default:     w_rx_state_nxt = c_ST_IDLE;
        endcase
    end

    // RX datapath: bit capture, holding register and single-cycle error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_tmr        <= '0;
            r_rx_idx        <= '0;
            r_rx_shift      <= '0;
            r_rx_par        <= 1'b0;
            r_rx_armed      <= 1'b0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_rx_frame_err  <= 1'b0;
            r_rx_parity_err <= 1'b0;
            r_rx_overrun    <= 1'b0;
        end else begin
            // IDLE is only ever entered with the line high, so the previous
            // sample doubles as the "armed" qualifier for edge detection.
            r_rx_armed      <= w_rx;
            r_rx_frame_err  <= 1'b0;
            r_rx_parity_err <= 1'b0;
            r_rx_overrun    <= 1'b0;
            if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

            if (r_rx_state == c_ST_IDLE || r_rx_state == c_ST_BREAK) begin
                r_rx_tmr <= '0;
                r_rx_idx <= '0;
            end else begin
                r_rx_tmr <= w_rx_wrap ? '0 : r_rx_tmr + 1'b1;
            end

            if (w_rx_tick) begin
                case (r_rx_state)
                    c_ST_DATA: begin
                        r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx != c_IDX_LAST) r_rx_idx <= r_rx_idx + 1'b1;
                    end
                    c_ST_PARITY: r_rx_par <= w_rx;
                    c_ST_STOP: begin
                        if (!w_rx) begin
                            r_rx_frame_err <= 1'b1;
                        end else if (c_HAS_PAR && ((^{r_rx_shift, r_rx_par}) != c_ODD)) begin
                            r_rx_parity_err <= 1'b1;
                        end else if (!r_rx_valid || rx_ready) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_rx_overrun <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
